apx_err_accum: RTL

- Downstream consumer of the approximate integer multipliers (btm, btm_trunc) and the exact reference multiplier (acc_multiplier).
- Takes paired 32-bit products per sample, exact and approximate, and computes the signed difference and absolute error.
- Accumulates error statistics over a fixed window of samples and presents one statistics record per window through a valid/ready handshake.
- Gives a hardware error-metric stage so NAB/rounding choices can be characterised in silicon or long simulations without file dumps.

---
 rtl/apx_err_accum.sv | 120 ++++++++++++
 1 files changed

// File: rtl/apx_err_accum.sv
// apx_err_accum: error-metric stage for approximate multipliers.
// Takes paired exact/approximate signed products, forms |acc_c - apx_c| per
// sample and accumulates sum (saturating), max and mismatch count over a
// window of WINDOW samples. One record per window leaves via valid/ready.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   in_valid/in_ready   sample handshake, acc_c/apx_c signed products
//   out_valid/out_ready record handshake
//   sum_abs_err         saturating sum of absolute errors
//   max_abs_err         largest absolute error in the window
//   mismatch_cnt        samples with acc_c != apx_c

// Per-sample difference: signed diff widened by one bit so the magnitude
// never overflows (largest |diff| is 2^IN_W - 1).
module apx_err_diff #(
  parameter int IN_W = 32
) (
  input  logic [IN_W-1:0] acc_c,
  input  logic [IN_W-1:0] apx_c,
  output logic [IN_W:0]   abs_err,
  output logic            neq
);
  logic [IN_W:0] diff;
  assign diff    = {acc_c[IN_W-1], acc_c} - {apx_c[IN_W-1], apx_c};
  assign abs_err = diff[IN_W] ? (~diff + 1'b1) : diff;
  assign neq     = (acc_c != apx_c);
endmodule

module apx_err_accum #(
  parameter int IN_W   = 32,
  parameter int WINDOW = 256,
  parameter int SUM_W  = 48,
  parameter int CNT_W  = $clog2(WINDOW) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  acc_c,
  input  logic [IN_W-1:0]  apx_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] sum_abs_err,
  output logic [IN_W:0]    max_abs_err,
  output logic [CNT_W-1:0] mismatch_cnt
);
  localparam logic [0:0] ACCUM  = 1'b0;
  localparam logic [0:0] REPORT = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] accept_cnt;
  logic [CNT_W-1:0] proc_cnt;
  // vld_pipe[0]: sample accepted this cycle; vld_pipe[1]: S1 holds a sample
  logic [1:0]       vld_pipe;
  logic [IN_W:0]    s1_abs;
  logic             s1_neq;

  logic [IN_W:0]    d_abs;
  logic             d_neq;
  logic [SUM_W:0]   sum_ext;
  logic             last;
  logic             fire_out;

  apx_err_diff #(.IN_W(IN_W)) u_diff (
    .acc_c   (acc_c),
    .apx_c   (apx_c),
    .abs_err (d_abs),
    .neq     (d_neq)
  );

  // Held low during reset so nothing is offered as accepted while cleared.
  assign in_ready  = rst && (state == ACCUM) && (accept_cnt < CNT_W'(WINDOW));
  assign vld_pipe[0] = in_valid && in_ready;
  assign out_valid = (state == REPORT);
  assign fire_out  = out_valid && out_ready;

  // One spare carry bit detects overflow; then clamp to all-ones.
  assign sum_ext = {1'b0, sum_abs_err} + {{(SUM_W-IN_W){1'b0}}, s1_abs};
  assign last    = vld_pipe[1] && (proc_cnt == CNT_W'(WINDOW - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ACCUM;
      accept_cnt   <= '0;
      proc_cnt     <= '0;
      vld_pipe[1]  <= 1'b0;
      s1_abs       <= '0;
      s1_neq       <= 1'b0;
      sum_abs_err  <= '0;
      max_abs_err  <= '0;
      mismatch_cnt <= '0;
    end else begin
      // S1: capture per-sample error on acceptance
      vld_pipe[1] <= vld_pipe[0];
      if (vld_pipe[0]) begin
        s1_abs     <= d_abs;
        s1_neq     <= d_neq;
        accept_cnt <= accept_cnt + 1'b1;
      end

      if (fire_out) begin
        // Record consumed: start a fresh window
        state        <= ACCUM;
        accept_cnt   <= '0;
        proc_cnt     <= '0;
        sum_abs_err  <= '0;
        max_abs_err  <= '0;
        mismatch_cnt <= '0;
      end else if (vld_pipe[1]) begin
        // S2: fold S1 into the window statistics
        sum_abs_err  <= sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
        if (s1_abs > max_abs_err) max_abs_err <= s1_abs;
        mismatch_cnt <= mismatch_cnt + CNT_W'(s1_neq);
        proc_cnt     <= proc_cnt + 1'b1;
        if (last) state <= REPORT;
      end
    end
  end
endmodule
